// File: rtl/fetch_seq_if.sv
`default_nettype none
//==============================================================================
// Module      : fetch_seq_if
// Description : Handshake and bus bundle between the control decoder and the
//               fetch/sequencing unit.
//               master modport : decoder / ALU side (drives run, jump and
//                                flag controls, LUT load port; observes PC,
//                                flags and status)
//               slave modport  : fetch_seq (drives prog_ctr, flags, busy,
//                                done and, with FETCH_CYCLE_CNT_EN defined,
//                                cycle_cnt)
// Options     : FETCH_CYCLE_CNT_EN adds the 32-bit cycle_cnt signal.
// Revision    : 1.0 - initial release
//==============================================================================
interface fetch_seq_if #(
    parameter int D = 10,
    parameter int L = 5,
    parameter int O = 6
);
    // Run handshake and sequencing controls
    logic         req;
    logic         stall;
    logic         halt_instr;
    logic         absj;
    logic         relj;
    logic [1:0]   cond_sel;
    logic         cond_neg;
    logic [L-1:0] lut_idx;
    logic [O-1:0] rel_off;
    // Flag load
    logic         flag_we;
    logic         zero_in;
    logic         pari_in;
    logic         carry_in;
    // LUT load port
    logic         lut_we;
    logic [L-1:0] lut_waddr;
    logic [D-1:0] lut_wdata;
    // Status
    logic [D-1:0] prog_ctr;
    logic [2:0]   flags;
    logic         busy;
    logic         done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [31:0]  cycle_cnt;
`endif

    modport master (
        output req, stall, halt_instr, absj, relj, cond_sel, cond_neg,
               lut_idx, rel_off, flag_we, zero_in, pari_in, carry_in,
               lut_we, lut_waddr, lut_wdata,
        input  prog_ctr, flags, busy,
`ifdef FETCH_CYCLE_CNT_EN
               cycle_cnt,
`endif
               done
    );

    modport slave (
        input  req, stall, halt_instr, absj, relj, cond_sel, cond_neg,
               lut_idx, rel_off, flag_we, zero_in, pari_in, carry_in,
               lut_we, lut_waddr, lut_wdata,
        output prog_ctr, flags, busy,
`ifdef FETCH_CYCLE_CNT_EN
               cycle_cnt,
`endif
               done
    );
endinterface
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
//==============================================================================
// Module      : fetch_seq
// Description : Fetch and sequencing unit. Owns the program counter, a
//               loadable branch-target LUT, the registered condition flags
//               and the req/busy/done run handshake. Supports conditional
//               absolute (LUT) and signed relative jumps, stall hold and halt.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - fetch_seq_if.slave (controls in; prog_ctr, flags,
//                       busy, done [, cycle_cnt] out, all registered)
// Options     : FETCH_CYCLE_CNT_EN - adds a saturating 32-bit run-cycle
//               counter on bus.cycle_cnt.
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_seq #(
    parameter int D     = 10,
    parameter int L     = 5,
    parameter int O     = 6,
    parameter int START = 0
) (
    input  wire logic  clk,
    input  wire logic  reset,
    fetch_seq_if.slave bus
);

    localparam logic [D-1:0] c_start = D'(START);
    localparam logic [D-1:0] c_one   = D'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [D-1:0] r_pc;
    logic [2:0]   r_flags;     // {carry, pari, zero}
    logic         r_busy;
    logic         r_done;
    logic [D-1:0] r_lut [2**L];

    logic         w_taken;
    logic [D-1:0] w_rel_ext;
    logic [D-1:0] w_next_pc;

    // Condition evaluated on the flags as registered before this edge, so a
    // flag load in the same cycle as a branch does not affect that branch.
    always_comb begin
        w_taken = 1'b1;
        case (bus.cond_sel)
            2'd1:    w_taken = r_flags[0] ^ bus.cond_neg;
            2'd2:    w_taken = r_flags[1] ^ bus.cond_neg;
            2'd3:    w_taken = r_flags[2] ^ bus.cond_neg;
            default: w_taken = 1'b1;
        endcase
    end

    // Sign-extend the offset; the D-bit add then wraps modulo 2^D both ways.
    assign w_rel_ext = D'(signed'(bus.rel_off));

    always_comb begin
        w_next_pc = r_pc + c_one;
        if (bus.absj && w_taken) begin
            w_next_pc = r_lut[bus.lut_idx];
        end else if (bus.relj && w_taken) begin
            w_next_pc = r_pc + w_rel_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_flags <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 2**L; i++) begin
                r_lut[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The LUT is only writable while no program is running.
                    if (bus.lut_we) begin
                        r_lut[bus.lut_waddr] <= bus.lut_wdata;
                    end
                    if (bus.req) begin
                        r_state <= S_RUN;
                        r_pc    <= c_start;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!bus.stall) begin
                        if (bus.flag_we) begin
                            r_flags <= {bus.carry_in, bus.pari_in, bus.zero_in};
                        end
                        // Halt takes priority over any jump and freezes the PC.
                        if (bus.halt_instr) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.req) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    // Counts every RUN cycle including stalls and the halt cycle; cleared
    // when a run starts and held (saturating) otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (r_state == S_IDLE && bus.req) begin
            r_cycle_cnt <= '0;
        end else if (r_state == S_RUN && r_cycle_cnt != 32'hFFFF_FFFF) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
`endif

    assign bus.prog_ctr = r_pc;
    assign bus.flags    = r_flags;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_fetch_seq
// Description : Self-checking bench for fetch_seq. Directed scenarios plus
//               randomized traffic compared against a behavioural model of
//               the run/halt handshake, jump rules and LUT.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fetch_seq;

    localparam int D     = 10;
    localparam int L     = 5;
    localparam int O     = 6;
    localparam int START = 0;
    localparam int PCMOD = 1 << D;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_seq_if #(.D(D), .L(L), .O(O)) bus ();

    fetch_seq #(.D(D), .L(L), .O(O), .START(START)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model state
    bit       m_running;
    bit       m_finished;
    int       m_pc;
    bit [2:0] m_flags;
    int       m_lut [1 << L];
    longint   m_cnt;

    int errors = 0;
    int checks = 0;
    int busy_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_running  = 1'b0;
        m_finished = 1'b0;
        m_pc       = 0;
        m_flags    = 3'b000;
        m_cnt      = 0;
        for (int i = 0; i < (1 << L); i++) m_lut[i] = 0;
    endtask

    // Applies one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit taken;
        int off;
        if (!m_running && !m_finished) begin
            if (bus.lut_we) m_lut[bus.lut_waddr] = int'(bus.lut_wdata);
            if (bus.req) begin
                m_running = 1'b1;
                m_pc      = START;
                m_cnt     = 0;
            end
        end else if (m_running) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (!bus.stall) begin
                if (bus.cond_sel == 2'd0) taken = 1'b1;
                else if (bus.cond_sel == 2'd1) taken = m_flags[0] ^ bus.cond_neg;
                else if (bus.cond_sel == 2'd2) taken = m_flags[1] ^ bus.cond_neg;
                else taken = m_flags[2] ^ bus.cond_neg;
                off = int'(bus.rel_off);
                if (off >= (1 << (O - 1))) off -= (1 << O);
                if (bus.halt_instr) begin
                    m_running  = 1'b0;
                    m_finished = 1'b1;
                end else if (bus.absj && taken) begin
                    m_pc = m_lut[bus.lut_idx];
                end else if (bus.relj && taken) begin
                    m_pc = ((m_pc + off) % PCMOD + PCMOD) % PCMOD;
                end else begin
                    m_pc = (m_pc + 1) % PCMOD;
                end
                if (bus.flag_we) m_flags = {bus.carry_in, bus.pari_in, bus.zero_in};
            end
        end else begin
            if (!bus.req) m_finished = 1'b0;
        end
    endtask

    task automatic check_all();
        check("prog_ctr", 64'(bus.prog_ctr), 64'(m_pc));
        check("flags", 64'(bus.flags), 64'(m_flags));
        check("busy", 64'(bus.busy), 64'(m_running));
        check("done", 64'(bus.done), 64'(m_finished));
`ifdef FETCH_CYCLE_CNT_EN
        check("cycle_cnt", 64'(bus.cycle_cnt), 64'(m_cnt));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        bus.req        = 1'b0;
        bus.stall      = 1'b0;
        bus.halt_instr = 1'b0;
        bus.absj       = 1'b0;
        bus.relj       = 1'b0;
        bus.cond_sel   = 2'd0;
        bus.cond_neg   = 1'b0;
        bus.lut_idx    = '0;
        bus.rel_off    = '0;
        bus.flag_we    = 1'b0;
        bus.zero_in    = 1'b0;
        bus.pari_in    = 1'b0;
        bus.carry_in   = 1'b0;
        bus.lut_we     = 1'b0;
        bus.lut_waddr  = '0;
        bus.lut_wdata  = '0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        model_reset();
        #12;
        check_all();
        check("rst_pc", 64'(bus.prog_ctr), 64'd0);
        reset = 1'b0;

        // Sequential run, halt at PC 4, req held high through DONE
        busy_n   = 0;
        bus.req  = 1'b1;
        step();
        busy_n += int'(bus.busy);
        repeat (4) begin
            step();
            busy_n += int'(bus.busy);
        end
        check("seq_pc4", 64'(bus.prog_ctr), 64'd4);
        bus.halt_instr = 1'b1;
        step();
        bus.halt_instr = 1'b0;
        check("busy_cycles", 64'(busy_n), 64'd5);
        check("seq_done", 64'(bus.done), 64'd1);
        check("halt_pc", 64'(bus.prog_ctr), 64'd4);
        step();
        step();
        check("done_hold", 64'(bus.done), 64'd1);
        bus.req = 1'b0;
        step();
        check("done_clear", 64'(bus.done), 64'd0);

        // LUT load in IDLE, absolute jump, LUT write ignored in RUN
        bus.lut_we    = 1'b1;
        bus.lut_waddr = 5'd3;
        bus.lut_wdata = 10'h2A5;
        step();
        bus.lut_waddr = 5'd5;
        bus.lut_wdata = 10'd1020;
        step();
        bus.lut_we = 1'b0;
        bus.req    = 1'b1;
        step();
        bus.req = 1'b0;
        step();
        step();
        check("pc2", 64'(bus.prog_ctr), 64'd2);
        bus.lut_we    = 1'b1;
        bus.lut_waddr = 5'd3;
        bus.lut_wdata = 10'h111;
        bus.absj      = 1'b1;
        bus.lut_idx   = 5'd3;
        step();
        check("absj_lut3", 64'(bus.prog_ctr), 64'h2A5);
        bus.absj = 1'b0;
        step();
        bus.lut_we = 1'b0;
        bus.absj   = 1'b1;
        step();
        check("lut3_kept", 64'(bus.prog_ctr), 64'h2A5);
        bus.absj       = 1'b0;
        bus.halt_instr = 1'b1;
        step();
        bus.halt_instr = 1'b0;
        step();

        // Relative jumps and wrap-around
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        step();
        bus.relj    = 1'b1;
        bus.rel_off = 6'b111101;
        step();
        check("rel_neg", 64'(bus.prog_ctr), 64'd1022);
        bus.relj = 1'b0;
        step();
        step();
        check("inc_wrap", 64'(bus.prog_ctr), 64'd0);
        bus.absj    = 1'b1;
        bus.lut_idx = 5'd5;
        step();
        bus.absj    = 1'b0;
        bus.relj    = 1'b1;
        bus.rel_off = 6'd31;
        step();
        check("rel_pos_wrap", 64'(bus.prog_ctr), 64'd27);

        // Conditional branch on registered zero flag
        bus.rel_off  = 6'd5;
        bus.cond_sel = 2'd1;
        bus.flag_we  = 1'b1;
        bus.zero_in  = 1'b1;
        step();
        check("cond_old_flag", 64'(bus.prog_ctr), 64'd28);
        check("flag_load", 64'(bus.flags), 64'd1);
        bus.flag_we = 1'b0;
        step();
        check("cond_taken", 64'(bus.prog_ctr), 64'd33);
        bus.cond_neg = 1'b1;
        step();
        check("cond_neg", 64'(bus.prog_ctr), 64'd34);
        clear_inputs();

        // Stall with halt and flag load pending
        bus.stall      = 1'b1;
        bus.halt_instr = 1'b1;
        bus.flag_we    = 1'b1;
        bus.carry_in   = 1'b1;
        repeat (3) step();
        check("stall_pc", 64'(bus.prog_ctr), 64'd34);
        check("stall_busy", 64'(bus.busy), 64'd1);
        bus.stall = 1'b0;
        step();
        check("stall_halt_done", 64'(bus.done), 64'd1);
        check("halt_flags", 64'(bus.flags), 64'd4);
        clear_inputs();
        step();

        // Reset mid-run at PC 7 clears the LUT
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        repeat (7) step();
        check("pc7", 64'(bus.prog_ctr), 64'd7);
        async_reset();
        check("rst_busy", 64'(bus.busy), 64'd0);
        bus.req = 1'b1;
        step();
        bus.req     = 1'b0;
        bus.absj    = 1'b1;
        bus.lut_idx = 5'd3;
        step();
        check("lut_cleared", 64'(bus.prog_ctr), 64'd0);
        clear_inputs();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bus.req        = ($urandom_range(0, 99) < 50);
            bus.stall      = ($urandom_range(0, 99) < 25);
            bus.halt_instr = ($urandom_range(0, 99) < 6);
            bus.absj       = ($urandom_range(0, 99) < 20);
            bus.relj       = ($urandom_range(0, 99) < 25);
            bus.cond_sel   = 2'($urandom);
            bus.cond_neg   = 1'($urandom);
            bus.lut_idx    = L'($urandom);
            bus.rel_off    = O'($urandom);
            bus.flag_we    = ($urandom_range(0, 99) < 50);
            bus.zero_in    = 1'($urandom);
            bus.pari_in    = 1'($urandom);
            bus.carry_in   = 1'($urandom);
            bus.lut_we     = ($urandom_range(0, 99) < 30);
            bus.lut_waddr  = L'($urandom);
            bus.lut_wdata  = D'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
# fetch_seq

Parametrised fetch and sequencing unit: owns the program counter, the branch-target lookup table, the registered condition flags and the req/done run handshake. It sits between the control decoder and the instruction ROM. It adds conditional branching on registered flags, a stall hold, signed relative jumps and a loadable jump LUT to the plain PC.

## Interface
Parameters:
- D, 10, program counter width; the ROM depth is 2^D.
- L, 5, LUT index width; the LUT holds 2^L entries of D bits.
- O, 6, signed relative-offset width; O ≤ D.
- START, 0, PC value loaded when a run starts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  run request (level).
- stall  in  1  hold the PC and flags this cycle (multi-cycle memory).
- halt_instr  in  1  the decoder flags the current instruction as halt.
- absj  in  1  absolute jump; target is lut[lut_idx].
- relj  in  1  relative jump; target is prog_ctr + sext(rel_off).
- cond_sel  in  2  condition select: 0 always, 1 zero, 2 parity, 3 carry.
- cond_neg  in  1  invert the selected condition; ignored when cond_sel=0.
- lut_idx  in  L  LUT index for absj.
- rel_off  in  O  signed two's-complement offset.
- flag_we  in  1  load the flag registers.
- zero_in, pari_in, carry_in  in  1 each  ALU flags.
- lut_we  in  1  LUT write strobe.
- lut_waddr  in  L  LUT write index.
- lut_wdata  in  D  LUT write data.
- prog_ctr  out  D  registered PC; drives the ROM address.
- flags  out  3  registered {carry, pari, zero}.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Reset (async): state=IDLE, prog_ctr=0, flags=0, busy=0, done=0, all LUT entries=0.
- IDLE:
  - req=1 → RUN and prog_ctr=START at the same edge.
  - LUT writes are accepted only in IDLE; lut_we is ignored in RUN and DONE.
- RUN, stall=1: prog_ctr, flags and state all hold. halt_instr, jump and flag_we inputs are ignored.
- RUN, stall=0, next-PC priority:
  - halt_instr=1 → DONE, PC holds. Halt wins over any jump.
  - else absj && taken → prog_ctr = lut[lut_idx].
  - else relj && taken → prog_ctr = prog_ctr + sign-extended rel_off, modulo 2^D (wraps both directions).
  - else prog_ctr+1 modulo 2^D; 2^D−1 wraps to 0.
- taken definition:
  - cond_sel=0 → 1.
  - otherwise the selected flag XOR cond_neg.
  - Uses the registered flags, i.e. the values before this cycle's flag_we update.
- Flags load from the *_in inputs only when state=RUN, stall=0, flag_we=1. A halt cycle with flag_we=1 still loads the flags.
- DONE:
  - PC and flags hold.
  - Stays in DONE while req=1; req=0 → IDLE.
  - PC and flags are retained into IDLE until the next start.
- req dropping during RUN has no effect; the run ends only on halt.
- Asserting reset mid-run returns to IDLE immediately and clears the LUT.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- req=1 sampled in IDLE at edge k:
  - prog_ctr=START and busy=1 after edge k.
  - The instruction at START is presented during cycle k+1.
- Jump/branch sampled at edge k → prog_ctr shows the target after edge k; no delay slot.
- halt sampled at edge k → done=1, busy=0 after edge k.
- req=0 sampled in DONE at edge k → done=0 after edge k.
- Minimum run: req high for 1 cycle in IDLE, then a halt at START gives busy for exactly 1 cycle.
- A LUT write at edge k is readable by absj in any later RUN cycle.

## Configuration
- FETCH_CYCLE_CNT_EN defined:
  - Adds output cycle_cnt (32 bits, registered).
  - Cleared on the IDLE→RUN edge.
  - Increments on every RUN cycle, stalled or not, including the halt cycle.
  - Saturates at 2^32−1 and holds its value in DONE and IDLE.
  - Reset value 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset mid-run at PC=7 → prog_ctr=0, busy=0, done=0 asynchronously; a subsequent absj to any index yields target 0.
- Sequential run: req, then halt_instr at PC=4 → busy for 5 cycles, prog_ctr holds at 4, done=1 until req=0, then done=0 the next cycle.
- Write lut[3]=0x2A5 in IDLE, start run, absj with lut_idx=3 and cond_sel=0 at PC=2 → next prog_ctr=0x2A5; an lut_we attempted in RUN leaves lut[3] unchanged.
- Relative branches:
  - relj with rel_off=−3 at PC=1 → prog_ctr=2^D−2 (1022).
  - relj with rel_off=+31 at PC=1020 → 27.
  - Increment from 1023 → 0.
- Conditional branch: flag_we with zero_in=1 in the same cycle as relj, cond_sel=1 → not taken (old zero=0), PC+1. The next relj with cond_sel=1 → taken; with cond_neg=1 instead → not taken.
- Stall for 3 cycles with halt_instr and flag_we asserted → PC, flags, state unchanged; the halt takes effect in the first unstalled cycle. With FETCH_CYCLE_CNT_EN defined, cycle_cnt includes the 3 stall cycles.
